// File: rtl/axi_lite_rr_arbiter_pkg.sv
// Shared types and constants for the N:1 AXI-lite arbiter.
// Holds the response codes, the channel FSM states and the arbitration mode selectors.
package axi_lite_rr_arbiter_pkg;

   typedef enum logic [1:0] {
      RespOkay   = 2'b00,
      RespSlverr = 2'b10
   } axi_resp_t;

   typedef enum logic [1:0] {
      StRdIdle,
      StRdAddr,
      StRdData
   } rd_state_t;

   typedef enum logic [1:0] {
      StWrIdle,
      StWrReq,
      StWrResp
   } wr_state_t;

   localparam int unsigned ArbFixed = 0;
   localparam int unsigned ArbRr    = 1;

   // Increment an index and wrap it to 0 at n.
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/axi_lite_rr_arbiter_rr_pick.sv
// Combinational requester pick: round-robin from ptr upward with wrap, or lowest index first.
module axi_lite_rr_arbiter_rr_pick
   import axi_lite_rr_arbiter_pkg::*;
#(
   parameter int unsigned N    = 4,
   parameter int unsigned MODE = ArbRr,
   localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    req,
   input  logic [IdxW-1:0] ptr,
   output logic [IdxW-1:0] gnt_idx,
   output logic            gnt_valid
);

   int unsigned base;
   int unsigned idx;

   always_comb begin
      gnt_idx   = '0;
      gnt_valid = |req;
      base      = (MODE == ArbRr) ? 32'(ptr) : 0;
      idx       = 0;
      // Walk downward so the nearest requester at or after base is the last one written.
      for (int i = int'(N) - 1; i >= 0; i--) begin
         idx = base + 32'(i);
         if (idx >= N) idx = idx - N;
         if (req[idx[IdxW-1:0]]) gnt_idx = idx[IdxW-1:0];
      end
   end

endmodule

// File: rtl/axi_lite_rr_arbiter.sv
// N:1 AXI-lite arbiter; read and write channels own independent FSMs, grants and pointers.
module axi_lite_rr_arbiter
   import axi_lite_rr_arbiter_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = 4,
   parameter int unsigned ARB_MODE    = 1,
   localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_MASTERS-1:0][31:0]      s_araddr,
   input  logic [NUM_MASTERS-1:0]            s_arvalid,
   output logic [NUM_MASTERS-1:0]            s_arready,
   output logic [NUM_MASTERS-1:0][31:0]      s_rdata,
   output logic [NUM_MASTERS-1:0][1:0]       s_rresp,
   output logic [NUM_MASTERS-1:0]            s_rvalid,
   input  logic [NUM_MASTERS-1:0]            s_rready,
   input  logic [NUM_MASTERS-1:0][31:0]      s_awaddr,
   input  logic [NUM_MASTERS-1:0]            s_awvalid,
   output logic [NUM_MASTERS-1:0]            s_awready,
   input  logic [NUM_MASTERS-1:0][31:0]      s_wdata,
   input  logic [NUM_MASTERS-1:0][3:0]       s_wstrb,
   input  logic [NUM_MASTERS-1:0]            s_wvalid,
   output logic [NUM_MASTERS-1:0]            s_wready,
   output logic [NUM_MASTERS-1:0][1:0]       s_bresp,
   output logic [NUM_MASTERS-1:0]            s_bvalid,
   input  logic [NUM_MASTERS-1:0]            s_bready,
   output logic [31:0]                       m_araddr,
   output logic                              m_arvalid,
   input  logic                              m_arready,
   input  logic [31:0]                       m_rdata,
   input  logic [1:0]                        m_rresp,
   input  logic                              m_rvalid,
   output logic                              m_rready,
   output logic [31:0]                       m_awaddr,
   output logic                              m_awvalid,
   input  logic                              m_awready,
   output logic [31:0]                       m_wdata,
   output logic [3:0]                        m_wstrb,
   output logic                              m_wvalid,
   input  logic                              m_wready,
   input  logic [1:0]                        m_bresp,
   input  logic                              m_bvalid,
   output logic                              m_bready,
   output logic                              rd_busy,
   output logic [IDX_W-1:0]                  rd_gnt_id,
   output logic                              wr_busy,
   output logic [IDX_W-1:0]                  wr_gnt_id
);

   rd_state_t        rd_state_q, rd_state_d;
   wr_state_t        wr_state_q, wr_state_d;
   logic [IDX_W-1:0] rd_gnt_q, rd_gnt_d, rd_ptr_q, rd_ptr_d;
   logic [IDX_W-1:0] wr_gnt_q, wr_gnt_d, wr_ptr_q, wr_ptr_d;
   logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic [IDX_W-1:0] rd_pick, wr_pick;
   logic             rd_pick_valid, wr_pick_valid;
   logic             ar_hs, r_hs, aw_hs, w_hs, b_hs;

   axi_lite_rr_arbiter_rr_pick #(.N(NUM_MASTERS), .MODE(ARB_MODE)) u_rd_pick (
      .req       (s_arvalid),
      .ptr       (rd_ptr_q),
      .gnt_idx   (rd_pick),
      .gnt_valid (rd_pick_valid)
   );

   axi_lite_rr_arbiter_rr_pick #(.N(NUM_MASTERS), .MODE(ARB_MODE)) u_wr_pick (
      .req       (s_awvalid),
      .ptr       (wr_ptr_q),
      .gnt_idx   (wr_pick),
      .gnt_valid (wr_pick_valid)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_state_q <= StRdIdle;
         rd_gnt_q   <= '0;
         rd_ptr_q   <= '0;
         wr_state_q <= StWrIdle;
         wr_gnt_q   <= '0;
         wr_ptr_q   <= '0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
      end else begin
         rd_state_q <= rd_state_d;
         rd_gnt_q   <= rd_gnt_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_state_q <= wr_state_d;
         wr_gnt_q   <= wr_gnt_d;
         wr_ptr_q   <= wr_ptr_d;
         aw_done_q  <= aw_done_d;
         w_done_q   <= w_done_d;
      end
   end

   // Read channel: routing is keyed only on the registered grant, never on live requests.
   always_comb begin
      rd_state_d = rd_state_q;
      rd_gnt_d   = rd_gnt_q;
      rd_ptr_d   = rd_ptr_q;
      m_araddr   = '0;
      m_arvalid  = 1'b0;
      m_rready   = 1'b0;
      s_arready  = '0;
      s_rdata    = '0;
      s_rresp    = {NUM_MASTERS{RespOkay}};
      s_rvalid   = '0;
      ar_hs      = 1'b0;
      r_hs       = 1'b0;
      case (rd_state_q)
         StRdIdle: begin
            if (rd_pick_valid) begin
               rd_gnt_d   = rd_pick;
               rd_state_d = StRdAddr;
            end
         end
         StRdAddr: begin
            m_araddr            = s_araddr[rd_gnt_q];
            m_arvalid           = s_arvalid[rd_gnt_q];
            s_arready[rd_gnt_q] = m_arready;
            ar_hs               = s_arvalid[rd_gnt_q] & m_arready;
            if (ar_hs) rd_state_d = StRdData;
         end
         StRdData: begin
            s_rdata[rd_gnt_q]  = m_rdata;
            s_rresp[rd_gnt_q]  = m_rresp;
            s_rvalid[rd_gnt_q] = m_rvalid;
            m_rready           = s_rready[rd_gnt_q];
            r_hs               = m_rvalid & s_rready[rd_gnt_q];
            if (r_hs) begin
               rd_state_d = StRdIdle;
               if (ARB_MODE == ArbRr) rd_ptr_d = IDX_W'(wrap_inc(32'(rd_gnt_q), NUM_MASTERS));
            end
         end
         default: rd_state_d = StRdIdle;
      endcase
   end

   // Write channel: AW and W complete independently; each is masked once its handshake is done.
   always_comb begin
      wr_state_d = wr_state_q;
      wr_gnt_d   = wr_gnt_q;
      wr_ptr_d   = wr_ptr_q;
      aw_done_d  = aw_done_q;
      w_done_d   = w_done_q;
      m_awaddr   = '0;
      m_awvalid  = 1'b0;
      m_wdata    = '0;
      m_wstrb    = '0;
      m_wvalid   = 1'b0;
      m_bready   = 1'b0;
      s_awready  = '0;
      s_wready   = '0;
      s_bresp    = {NUM_MASTERS{RespOkay}};
      s_bvalid   = '0;
      aw_hs      = 1'b0;
      w_hs       = 1'b0;
      b_hs       = 1'b0;
      case (wr_state_q)
         StWrIdle: begin
            if (wr_pick_valid) begin
               wr_gnt_d   = wr_pick;
               wr_state_d = StWrReq;
            end
         end
         StWrReq: begin
            m_awaddr            = s_awaddr[wr_gnt_q];
            m_awvalid           = s_awvalid[wr_gnt_q] & ~aw_done_q;
            s_awready[wr_gnt_q] = m_awready & ~aw_done_q;
            m_wdata             = s_wdata[wr_gnt_q];
            m_wstrb             = s_wstrb[wr_gnt_q];
            m_wvalid            = s_wvalid[wr_gnt_q] & ~w_done_q;
            s_wready[wr_gnt_q]  = m_wready & ~w_done_q;
            aw_hs               = s_awvalid[wr_gnt_q] & ~aw_done_q & m_awready;
            w_hs                = s_wvalid[wr_gnt_q] & ~w_done_q & m_wready;
            if (aw_hs) aw_done_d = 1'b1;
            if (w_hs) w_done_d = 1'b1;
            if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) wr_state_d = StWrResp;
         end
         StWrResp: begin
            s_bresp[wr_gnt_q]  = m_bresp;
            s_bvalid[wr_gnt_q] = m_bvalid;
            m_bready           = s_bready[wr_gnt_q];
            b_hs               = m_bvalid & s_bready[wr_gnt_q];
            if (b_hs) begin
               wr_state_d = StWrIdle;
               aw_done_d  = 1'b0;
               w_done_d   = 1'b0;
               if (ARB_MODE == ArbRr) wr_ptr_d = IDX_W'(wrap_inc(32'(wr_gnt_q), NUM_MASTERS));
            end
         end
         default: wr_state_d = StWrIdle;
      endcase
   end

   assign rd_busy   = (rd_state_q != StRdIdle);
   assign rd_gnt_id = rd_gnt_q;
   assign wr_busy   = (wr_state_q != StWrIdle);
   assign wr_gnt_id = wr_gnt_q;

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Directed bench for axi_lite_rr_arbiter: a round-robin instance plus a fixed-priority instance.
module tb_axi_lite_rr_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [3:0][31:0] s_araddr, s_awaddr, s_wdata, s_rdata;
   logic [3:0][3:0]  s_wstrb;
   logic [3:0][1:0]  s_rresp, s_bresp;
   logic [3:0] s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
   logic [3:0] s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
   logic [31:0] m_araddr, m_awaddr, m_wdata, m_rdata;
   logic [3:0]  m_wstrb;
   logic [1:0]  m_rresp, m_bresp;
   logic m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
   logic m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
   logic rd_busy, wr_busy;
   logic [1:0] rd_gnt_id, wr_gnt_id;

   logic [3:0] fx_arvalid, fx_s_arready, fx_s_rvalid, fx_s_awready, fx_s_wready, fx_s_bvalid;
   logic [3:0][31:0] fx_s_rdata;
   logic [3:0][1:0]  fx_s_rresp, fx_s_bresp;
   logic [31:0] fx_m_araddr, fx_m_awaddr, fx_m_wdata;
   logic [3:0]  fx_m_wstrb;
   logic fx_m_arvalid, fx_m_rready, fx_m_awvalid, fx_m_wvalid, fx_m_bready;
   logic fx_m_arready, fx_m_rvalid;
   logic fx_rd_busy, fx_wr_busy;
   logic [1:0] fx_rd_gnt_id, fx_wr_gnt_id;

   axi_lite_rr_arbiter #(.NUM_MASTERS(4), .ARB_MODE(1)) dut (
      .clk(clk), .rst(rst),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .rd_busy(rd_busy), .rd_gnt_id(rd_gnt_id), .wr_busy(wr_busy), .wr_gnt_id(wr_gnt_id)
   );

   axi_lite_rr_arbiter #(.NUM_MASTERS(4), .ARB_MODE(0)) dut_fx (
      .clk(clk), .rst(rst),
      .s_araddr(s_araddr), .s_arvalid(fx_arvalid), .s_arready(fx_s_arready),
      .s_rdata(fx_s_rdata), .s_rresp(fx_s_rresp), .s_rvalid(fx_s_rvalid), .s_rready(s_rready),
      .s_awaddr(s_awaddr), .s_awvalid(4'b0000), .s_awready(fx_s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(4'b0000), .s_wready(fx_s_wready),
      .s_bresp(fx_s_bresp), .s_bvalid(fx_s_bvalid), .s_bready(s_bready),
      .m_araddr(fx_m_araddr), .m_arvalid(fx_m_arvalid), .m_arready(fx_m_arready),
      .m_rdata(m_rdata), .m_rresp(2'b00), .m_rvalid(fx_m_rvalid), .m_rready(fx_m_rready),
      .m_awaddr(fx_m_awaddr), .m_awvalid(fx_m_awvalid), .m_awready(1'b0),
      .m_wdata(fx_m_wdata), .m_wstrb(fx_m_wstrb), .m_wvalid(fx_m_wvalid), .m_wready(1'b0),
      .m_bresp(2'b00), .m_bvalid(1'b0), .m_bready(fx_m_bready),
      .rd_busy(fx_rd_busy), .rd_gnt_id(fx_rd_gnt_id),
      .wr_busy(fx_wr_busy), .wr_gnt_id(fx_wr_gnt_id)
   );

   typedef struct {
      logic [3:0] mask;
      logic [1:0] exp;
   } rd_vec_t;

   rd_vec_t vecs [10];
   int total = 0;
   int bad = 0;
   int aw_hs_cnt = 0;
   int cnt0;
   logic [31:0] rdat;

   always @(posedge clk) if (m_awvalid && m_awready) aw_hs_cnt <= aw_hs_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rr_ar();
      int n = 0;
      while (!m_arvalid && n < 8) begin
         tick();
         n++;
      end
      check("rr_ar_timeout", 32'(m_arvalid), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Ptr starts at 0; each row is one full read and advances ptr past the winner.
      vecs[0] = '{4'b1111, 2'd0};
      vecs[1] = '{4'b1111, 2'd1};
      vecs[2] = '{4'b1111, 2'd2};
      vecs[3] = '{4'b1111, 2'd3};
      vecs[4] = '{4'b1111, 2'd0};
      vecs[5] = '{4'b0001, 2'd0};
      vecs[6] = '{4'b1000, 2'd3};
      vecs[7] = '{4'b0110, 2'd1};
      vecs[8] = '{4'b0011, 2'd0};
      vecs[9] = '{4'b0100, 2'd2};

      rst = 1'b1;
      s_arvalid = '0; s_awvalid = '0; s_wvalid = '0; s_rready = '1; s_bready = '1;
      s_awaddr = '0; s_wdata = '0; s_wstrb = '0;
      for (int i = 0; i < 4; i++) s_araddr[i] = 32'(i * 16);
      m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0;
      m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = '0;
      fx_arvalid = '0; fx_m_arready = 0; fx_m_rvalid = 0;

      #12;
      check("rst_m_arvalid", 32'(m_arvalid), 0);
      check("rst_m_awvalid", 32'(m_awvalid), 0);
      check("rst_m_wvalid", 32'(m_wvalid), 0);
      check("rst_busy", 32'({rd_busy, wr_busy}), 0);
      check("rst_gnt", 32'({rd_gnt_id, wr_gnt_id}), 0);
      check("rst_s_ready", 32'({s_arready, s_awready, s_wready}), 0);
      @(negedge clk) rst = 1'b0;
      tick();

      // Fixed priority: masters 1 and 3 request forever, 1 always wins.
      fx_arvalid = 4'b1010;
      for (int t = 0; t < 3; t++) begin
         int n = 0;
         tick();
         while (!fx_m_arvalid && n < 8) begin tick(); n++; end
         check("fx_ar_timeout", 32'(fx_m_arvalid), 1);
         check("fx_gnt", 32'(fx_rd_gnt_id), 1);
         fx_m_arready = 1; #1;
         check("fx_s_arready", 32'(fx_s_arready), 32'b0010);
         tick();
         fx_m_arready = 0; fx_m_rvalid = 1; #1;
         check("fx_s_rvalid", 32'(fx_s_rvalid), 32'b0010);
         tick();
         fx_m_rvalid = 0;
      end
      fx_arvalid = '0;
      tick();

      // Round-robin table.
      for (int r = 0; r < 10; r++) begin
         s_arvalid = vecs[r].mask;
         tick();
         wait_rr_ar();
         check("rr_gnt", 32'(rd_gnt_id), 32'(vecs[r].exp));
         check("rr_araddr", m_araddr, 32'(vecs[r].exp) * 16);
         m_arready = 1;
         rdat = 32'hA0 + (m_araddr >> 4);
         tick();
         m_arready = 0; s_arvalid = '0; m_rvalid = 1; m_rdata = rdat;
         #1;
         check("rr_s_rvalid", 32'(s_rvalid), 32'(4'b0001 << vecs[r].exp));
         check("rr_s_rdata", s_rdata[vecs[r].exp], 32'hA0 + 32'(vecs[r].exp));
         tick();
         m_rvalid = 0; #1;
         check("rr_idle", 32'(rd_busy), 0);
      end

      // Reset in R_DATA abandons the read.
      s_arvalid = 4'b0100;
      tick();
      check("rst_mid_gnt", 32'(rd_gnt_id), 2);
      m_arready = 1;
      tick();
      m_arready = 0; s_arvalid = '0; m_rvalid = 1; #1;
      check("rst_mid_busy_pre", 32'(rd_busy), 1);
      rst = 1'b1; #1;
      check("rst_mid_rvalid", 32'({s_rvalid, m_arvalid, m_rready}), 0);
      check("rst_mid_busy", 32'(rd_busy), 0);
      check("rst_mid_gnt_id", 32'(rd_gnt_id), 0);
      m_rvalid = 0;
      @(negedge clk) rst = 1'b0;
      tick();

      // Concurrent read by 2 and write by 0.
      s_araddr[2] = 32'h100; s_awaddr[0] = 32'h40; s_wdata[0] = 32'hDEADBEEF; s_wstrb[0] = 4'hF;
      s_arvalid = 4'b0100; s_awvalid = 4'b0001; s_wvalid = 4'b0001;
      tick();
      check("cc_rd_gnt", 32'(rd_gnt_id), 2);
      check("cc_wr_gnt", 32'(wr_gnt_id), 0);
      check("cc_araddr", m_araddr, 32'h100);
      check("cc_wdata", m_wdata, 32'hDEADBEEF);
      check("cc_wstrb", 32'(m_wstrb), 32'hF);
      check("cc_valids", 32'({m_arvalid, m_awvalid, m_wvalid}), 32'b111);
      m_arready = 1; m_awready = 1; m_wready = 1;
      tick();
      m_arready = 0; m_awready = 0; m_wready = 0;
      s_arvalid = '0; s_awvalid = '0; s_wvalid = '0;
      m_rvalid = 1; m_rdata = 32'h55; m_bvalid = 1; m_bresp = 2'b00; #1;
      check("cc_s_rvalid", 32'(s_rvalid), 32'b0100);
      check("cc_s_bvalid", 32'(s_bvalid), 32'b0001);
      tick();
      m_rvalid = 0; m_bvalid = 0; #1;
      check("cc_idle", 32'({rd_busy, wr_busy}), 0);

      // Split AW/W: AW accepted three cycles before W; awready stays high meanwhile.
      s_awaddr[1] = 32'h80; s_wdata[1] = 32'h12345678; s_wstrb[1] = 4'h3;
      s_awvalid = 4'b0010; s_wvalid = 4'b0010;
      cnt0 = aw_hs_cnt;
      tick();
      check("sp_wr_gnt", 32'(wr_gnt_id), 1);
      m_awready = 1;
      tick();
      check("sp_wvalid_held", 32'(m_wvalid), 1);
      for (int k = 0; k < 2; k++) begin
         check("sp_awvalid_masked", 32'({m_awvalid, s_awready[1]}), 0);
         tick();
      end
      m_wready = 1;
      tick();
      m_wready = 0; m_awready = 0;
      check("sp_in_resp", 32'({wr_busy, m_wvalid, m_awvalid}), 32'b100);
      check("sp_aw_hs_once", 32'(aw_hs_cnt - cnt0), 1);
      s_awvalid = '0; s_wvalid = '0; m_bvalid = 1; m_bresp = 2'b10; #1;
      check("sp_s_bvalid", 32'(s_bvalid), 32'b0010);
      check("sp_s_bresp", 32'(s_bresp), 32'b0000_1000);
      tick();
      m_bvalid = 0; m_bresp = 2'b00; #1;
      check("sp_idle", 32'(wr_busy), 0);

      // Backpressure: owner 3 holds rready low for 5 cycles while 0 keeps requesting.
      s_arvalid = 4'b1001;
      tick();
      check("bp_gnt", 32'(rd_gnt_id), 3);
      m_arready = 1;
      tick();
      m_arready = 0; s_arvalid = 4'b0001; m_rvalid = 1; m_rdata = 32'h77; s_rready = 4'b0111;
      #1;
      for (int k = 0; k < 5; k++) begin
         check("bp_rvalid_owner", 32'(s_rvalid), 32'b1000);
         check("bp_held", 32'({rd_busy, rd_gnt_id, m_rready, m_arvalid}), 32'b1_11_0_0);
         tick();
      end
      s_rready = 4'b1111; #1;
      check("bp_rready", 32'(m_rready), 1);
      tick();
      m_rvalid = 0;
      tick();
      check("bp_next_gnt", 32'({m_arvalid, rd_gnt_id}), 32'b1_00);
      m_arready = 1;
      tick();
      m_arready = 0; s_arvalid = '0; m_rvalid = 1; #1;
      check("bp_next_rvalid", 32'(s_rvalid), 32'b0001);
      tick();
      m_rvalid = 0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
